// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: packs pixels into {8'h00,r,g,b} words, buffers them and burst-writes frames to ping-pong DDR regions.
// Latency: a pixel reaches the burst master one cycle after it is presented; back-to-back bursts chain with no idle cycle.
// Backpressure: none on the pixel input; avm_waitrequest stalls the master, and a full FIFO drops pixels and sets overflow.
module frame_buffer_writer #(
  parameter logic [31:0] BASE_ADDR_0  = 32'h3000_0000,
  parameter logic [31:0] BASE_ADDR_1  = 32'h3040_0000,
  parameter int          FRAME_PIXELS = 921600,
  parameter int          BURST_LEN    = 16,
  parameter int          FIFO_DEPTH   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  r_fb,
  input  logic [7:0]  g_fb,
  input  logic [7:0]  b_fb,
  input  logic        data_fb_valid,
  input  logic        sop_fb,
  input  logic        eop_fb,
  output logic [31:0] avm_address,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  output logic [4:0]  avm_burstcount,
  input  logic        avm_waitrequest,
  output logic        frame_done,
  output logic [31:0] rd_base_addr,
  output logic        overflow,
  output logic        sop_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(FRAME_PIXELS + 1);
  localparam logic [PW-1:0] MAX_PIX  = PW'(FRAME_PIXELS);
  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0]   BLEN_32  = 32'(BURST_LEN);

  typedef enum logic [1:0] {WAIT_SOP, IN_FRAME, WAIT_FLUSH} in_state_t;
  typedef enum logic {M_IDLE, M_BURST} m_state_t;

  in_state_t r_in_state, w_in_nxt;
  m_state_t  r_m_state, w_m_nxt;

  logic [32:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [PW-1:0] r_pix_cnt, r_eop_len, r_offset;
  logic          r_eop_pending, r_buf_sel;
  logic [31:0]   r_addr, r_rd_base;
  logic [4:0]    r_bcnt, r_beats_left;
  logic          r_frame_done, r_overflow, r_sop_err;

  logic          w_frame_pix, w_is_eop, w_sop_bad, w_over_limit, w_push;
  logic [PW-1:0] w_idx;
  logic [AW:0]   w_fill;
  logic [32:0]   w_head;
  logic          w_accept, w_last_beat, w_complete, w_can_start, w_load;
  logic [31:0]   w_eff_fill, w_eff_off, w_remain, w_cur_base;
  logic [4:0]    w_blen;

  // Input FSM: decide which valid pixels belong to the current frame and where the frame ends
  always_comb begin
    w_in_nxt    = r_in_state;
    w_frame_pix = 1'b0;
    w_is_eop    = 1'b0;
    w_sop_bad   = 1'b0;
    case (r_in_state)
      WAIT_SOP: begin
        if (data_fb_valid && sop_fb) begin
          w_frame_pix = 1'b1;
          w_is_eop    = eop_fb;
          w_in_nxt    = eop_fb ? WAIT_FLUSH : IN_FRAME;
        end
      end
      IN_FRAME: begin
        if (data_fb_valid) begin
          w_frame_pix = 1'b1;
          w_is_eop    = eop_fb;
          w_sop_bad   = sop_fb;
          if (eop_fb) w_in_nxt = WAIT_FLUSH;
        end
      end
      WAIT_FLUSH: begin
        w_sop_bad = data_fb_valid && sop_fb;
        if (!r_eop_pending) w_in_nxt = WAIT_SOP;
      end
      default: w_in_nxt = WAIT_SOP;
    endcase
  end

  assign w_idx        = (r_in_state == WAIT_SOP) ? '0 : r_pix_cnt;
  assign w_fill       = r_wr_ptr - r_rd_ptr;
  assign w_over_limit = w_frame_pix && (w_idx >= MAX_PIX);
  assign w_push       = w_frame_pix && !w_over_limit && (w_fill != DEPTH_V);

  // FIFO storage: tag bit marks the last word of a frame
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {w_is_eop, 8'h00, r_fb, g_fb, b_fb};
  end

  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_accept    = (r_m_state == M_BURST) && !avm_waitrequest;
  assign w_last_beat = w_accept && (r_beats_left == 5'd1);
  assign w_complete  = w_accept && (w_head[32] || (r_eop_pending && (r_offset + PW'(1) == r_eop_len)));
  assign w_cur_base  = r_buf_sel ? BASE_ADDR_1 : BASE_ADDR_0;

  // Burst launch decision, evaluated on the post-pop view so a new burst can follow the last beat directly
  always_comb begin
    w_eff_fill  = 32'(w_fill) - 32'(w_accept);
    w_eff_off   = 32'(r_offset) + 32'(w_accept);
    w_remain    = 32'(r_eop_len) - w_eff_off;
    w_can_start = (w_eff_fill >= BLEN_32) ||
                  (r_eop_pending && (w_remain != 32'd0) && (w_eff_fill >= w_remain));
    w_blen      = (r_eop_pending && (w_remain < BLEN_32)) ? 5'(w_remain) : 5'(BURST_LEN);
    w_load      = ((r_m_state == M_IDLE) || w_last_beat) && !w_complete && w_can_start;
  end

  // Master FSM next state: stay in burst when chaining, fall back to idle after the last beat
  always_comb begin
    w_m_nxt = r_m_state;
    if (w_load)           w_m_nxt = M_BURST;
    else if (w_last_beat) w_m_nxt = M_IDLE;
  end

  // State registers for both FSMs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_state <= WAIT_SOP;
      r_m_state  <= M_IDLE;
    end else begin
      r_in_state <= w_in_nxt;
      r_m_state  <= w_m_nxt;
    end
  end

  // Frame bookkeeping, FIFO pointers, burst registers and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_pix_cnt     <= '0;
      r_eop_len     <= '0;
      r_offset      <= '0;
      r_eop_pending <= 1'b0;
      r_buf_sel     <= 1'b0;
      r_addr        <= '0;
      r_bcnt        <= '0;
      r_beats_left  <= '0;
      r_frame_done  <= 1'b0;
      r_rd_base     <= BASE_ADDR_1;
      r_overflow    <= 1'b0;
      r_sop_err     <= 1'b0;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_accept) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);

      // pix_cnt saturates at the frame limit; dropped pixels still advance it
      if (w_frame_pix) begin
        if (r_in_state == WAIT_SOP)   r_pix_cnt <= PW'(1);
        else if (r_pix_cnt < MAX_PIX) r_pix_cnt <= r_pix_cnt + PW'(1);
      end

      if (w_frame_pix && w_is_eop) r_eop_len <= w_over_limit ? MAX_PIX : w_idx + PW'(1);

      if (w_complete)                   r_eop_pending <= 1'b0;
      else if (w_frame_pix && w_is_eop) r_eop_pending <= 1'b1;

      if (w_complete)    r_offset <= '0;
      else if (w_accept) r_offset <= r_offset + PW'(1);

      if (w_load) begin
        r_addr       <= w_cur_base + (w_eff_off << 2);
        r_bcnt       <= w_blen;
        r_beats_left <= w_blen;
      end else if (w_accept) begin
        r_beats_left <= r_beats_left - 5'd1;
      end

      r_frame_done <= w_complete;
      if (w_complete) begin
        r_rd_base <= w_cur_base;
        r_buf_sel <= ~r_buf_sel;
      end

      if (w_frame_pix && !w_push) r_overflow <= 1'b1;
      if (w_sop_bad)              r_sop_err  <= 1'b1;
    end
  end

  assign avm_write      = (r_m_state == M_BURST);
  assign avm_writedata  = avm_write ? w_head[31:0] : 32'h0;
  assign avm_address    = r_addr;
  assign avm_burstcount = r_bcnt;
  assign avm_byteenable = 4'hF;
  assign frame_done     = r_frame_done;
  assign rd_base_addr   = r_rd_base;
  assign overflow       = r_overflow;
  assign sop_err        = r_sop_err;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: random pixel frames and waitrequest patterns,
// expected bursts/words/frame completions queued at stimulus time and
// checked by an independent monitor on the falling edge.
`timescale 1ns/1ps
module tb_frame_buffer_writer;
  localparam logic [31:0] B0 = 32'h3000_0000;
  localparam logic [31:0] B1 = 32'h3040_0000;
  localparam int BL = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  r_fb, g_fb, b_fb;
  logic        data_fb_valid, sop_fb, eop_fb;
  logic [31:0] avm_address, avm_writedata, rd_base_addr;
  logic        avm_write, avm_waitrequest, frame_done, overflow, sop_err;
  logic [3:0]  avm_byteenable;
  logic [4:0]  avm_burstcount;

  frame_buffer_writer dut (
    .clk(clk), .reset(reset),
    .r_fb(r_fb), .g_fb(g_fb), .b_fb(b_fb),
    .data_fb_valid(data_fb_valid), .sop_fb(sop_fb), .eop_fb(eop_fb),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest),
    .frame_done(frame_done), .rd_base_addr(rd_base_addr),
    .overflow(overflow), .sop_err(sop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [4:0] cnt; } burst_t;
  burst_t      exp_bursts[$];
  logic [31:0] exp_words[$];
  logic [31:0] exp_done[$];

  int checks = 0;
  int errors = 0;
  bit model_buf = 1'b0;
  logic [31:0] last_base = B1;
  int wr_mode = 0;   // 0: never stall, 1: 50% random stall, 2: always stall

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing", nm, act);
  endtask

  // waitrequest generator, changes just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (wr_mode == 2)      avm_waitrequest = 1'b1;
    else if (wr_mode == 1) avm_waitrequest = 1'($urandom_range(0, 1));
    else                   avm_waitrequest = 1'b0;
  end

  // Monitor: compares every burst header, accepted word and frame completion with the queues
  int          m_left = 0;
  bit          m_stall = 1'b0;
  bit          m_prev_done = 1'b0;
  logic [31:0] m_addr, m_data;
  logic [4:0]  m_cnt;
  burst_t      mb;
  always @(negedge clk) begin
    if (reset) begin
      m_left = 0;
      m_stall = 1'b0;
      m_prev_done = 1'b0;
    end else begin
      if (m_stall && !avm_write) chk("write_held_in_stall", 32'(avm_write), 32'd1);
      if (avm_write) begin
        if (m_stall) begin
          chk("stall_addr", avm_address, m_addr);
          chk("stall_count", 32'(avm_burstcount), 32'(m_cnt));
          chk("stall_data", avm_writedata, m_data);
        end else if (m_left == 0) begin
          if (exp_bursts.size() == 0) begin
            flag("unexpected_burst", avm_address);
            m_left = int'(avm_burstcount);
          end else begin
            mb = exp_bursts.pop_front();
            chk("burst_addr", avm_address, mb.addr);
            chk("burst_count", 32'(avm_burstcount), 32'(mb.cnt));
            m_left = int'(mb.cnt);
          end
        end else begin
          chk("beat_addr_hold", avm_address, m_addr);
          chk("beat_count_hold", 32'(avm_burstcount), 32'(m_cnt));
        end
        m_addr = avm_address;
        m_cnt  = avm_burstcount;
        m_data = avm_writedata;
        if (!avm_waitrequest) begin
          if (exp_words.size() == 0) flag("unexpected_word", avm_writedata);
          else chk("writedata", avm_writedata, exp_words.pop_front());
          m_left--;
          m_stall = 1'b0;
        end else begin
          m_stall = 1'b1;
        end
      end else begin
        m_stall = 1'b0;
      end
      if (frame_done) begin
        chk("frame_done_pulse", 32'(m_prev_done), 32'd0);
        if (exp_done.size() == 0) flag("unexpected_frame_done", rd_base_addr);
        else chk("rd_base_on_done", rd_base_addr, exp_done.pop_front());
      end
      m_prev_done = frame_done;
    end
  end

  task automatic drive_pix(input bit v, input bit s, input bit e, input logic [23:0] p);
    @(posedge clk);
    #1;
    data_fb_valid = v;
    sop_fb = s;
    eop_fb = e;
    {r_fb, g_fb, b_fb} = p;
  endtask

  // Queue the spec-level expectation for a frame of n pixels, then drive it.
  // keep = words the FIFO can hold; a frame completes only if all n are kept.
  task automatic send_frame(input int n, input int junk, input int sop2, input int keep, input int gap_pct);
    logic [23:0] pix[$];
    int kw;
    int len;
    for (int i = 0; i < n; i++) pix.push_back(24'($urandom));
    kw = (keep < n) ? keep : n;
    for (int off = 0; off < kw; off += BL) begin
      len = (n - off < BL) ? n - off : BL;
      exp_bursts.push_back({(model_buf ? B1 : B0) + 32'(4 * off), 5'(len)});
    end
    for (int i = 0; i < kw; i++) exp_words.push_back({8'h00, pix[i]});
    if (kw == n) begin
      last_base = model_buf ? B1 : B0;
      exp_done.push_back(last_base);
      model_buf = !model_buf;
    end
    for (int j = 0; j < junk; j++) drive_pix(1'b1, 1'b0, 1'b0, 24'($urandom));
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) drive_pix(1'b0, 1'b0, 1'b0, 24'h0);
      drive_pix(1'b1, (i == 0) || (i == sop2), i == n - 1, pix[i]);
    end
    drive_pix(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((exp_words.size() != 0 || exp_bursts.size() != 0 || exp_done.size() != 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (exp_words.size() != 0 || exp_bursts.size() != 0 || exp_done.size() != 0) begin
      flag("drain_timeout", 32'(exp_words.size()));
      exp_words.delete();
      exp_bursts.delete();
      exp_done.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_words.delete();
    exp_bursts.delete();
    exp_done.delete();
    model_buf = 1'b0;
    last_base = B1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_address", avm_address, 32'd0);
    chk("rst_burstcount", 32'(avm_burstcount), 32'd0);
    chk("rst_writedata", avm_writedata, 32'd0);
    chk("rst_byteenable", 32'(avm_byteenable), 32'hF);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_rd_base", rd_base_addr, B1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sop_err", 32'(sop_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    data_fb_valid = 1'b0;
    sop_fb = 1'b0;
    eop_fb = 1'b0;
    {r_fb, g_fb, b_fb} = 24'h0;
    avm_waitrequest = 1'b0;
    do_reset();

    // single 40-pixel frame, no stalls
    wr_mode = 0;
    send_frame(40, 0, -1, 1000, 0);
    wait_drain(2000);
    chk("f1_rd_base", rd_base_addr, B0);
    chk("f1_overflow", 32'(overflow), 32'd0);
    chk("f1_sop_err", 32'(sop_err), 32'd0);

    // second frame goes to the other buffer
    send_frame(40, 0, -1, 1000, 0);
    wait_drain(2000);
    chk("f2_rd_base", rd_base_addr, B1);

    // random 50% waitrequest
    wr_mode = 1;
    send_frame(40, 0, -1, 1000, 0);
    wait_drain(2000);
    chk("f3_rd_base", rd_base_addr, B0);
    chk("f3_overflow", 32'(overflow), 32'd0);

    // random frames: length, leading junk, input gaps and stalls
    for (int k = 0; k < 6; k++) begin
      send_frame(int'($urandom_range(1, 60)), int'($urandom_range(0, 3)), -1, 1000, 30);
      wait_drain(3000);
      chk("rand_rd_base", rd_base_addr, last_base);
    end
    chk("rand_overflow", 32'(overflow), 32'd0);
    chk("rand_sop_err", 32'(sop_err), 32'd0);

    // pre-sop junk and a stray sop mid-frame
    wr_mode = 0;
    send_frame(20, 5, 10, 1000, 0);
    wait_drain(2000);
    chk("sop_err_set", 32'(sop_err), 32'd1);
    chk("sop_rd_base", rd_base_addr, last_base);
    chk("sop_overflow", 32'(overflow), 32'd0);

    // stall for the whole 100-pixel frame: only the first 64 pixels survive
    wr_mode = 2;
    send_frame(100, 0, -1, 64, 0);
    wr_mode = 0;
    wait_drain(2000);
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (20) @(posedge clk);

    do_reset();

    // one-pixel frame
    send_frame(1, 0, -1, 1000, 0);
    wait_drain(2000);
    chk("one_pix_rd_base", rd_base_addr, B0);
    chk("one_pix_overflow", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
